// File: rtl/imem_ctrl_pkg.sv
// Shared types and helpers for the instruction-memory load/fetch controller.
package imem_ctrl_pkg;

    localparam int unsigned SIZE_DEFAULT = 14;
    localparam int unsigned IMEM_BYTES   = 1 << SIZE_DEFAULT;

    typedef enum logic [2:0] {
        WAIT,
        LOAD,
        DONE,
        RUN,
        ERR
    } imem_state_t;

    // Misaligned fetches and fetches at or beyond the last word (0x..FFC) are flagged.
    function automatic logic fetch_addr_bad(input logic [63:0] addr, input int unsigned size_log2);
        logic [63:0] top_word;
        top_word = (64'(1) << size_log2) - 64'd4;
        return (addr[1:0] != 2'b00) || (addr >= top_word);
    endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Streams a program image byte-by-byte into instruction memory while the core is stalled,
// then releases the core into RUN and monitors fetch addresses.
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned SIZE          = SIZE_DEFAULT,
    parameter bit          BOOT_AUTO     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [7:0]               ld_byte,
    input  logic                     ld_last,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    output logic                     mem_we,
    output logic [SIZE-1:0]          mem_waddr,
    output logic [7:0]               mem_wdata,
    output logic [SIZE-1:0]          mem_raddr,
    output logic                     cpu_stall,
    output logic                     load_done,
    output logic                     load_err,
    output logic [SIZE:0]            byte_count,
    output logic                     fetch_fault
);

    localparam imem_state_t     RESET_STATE = BOOT_AUTO ? RUN : WAIT;
    localparam logic [SIZE-1:0] PTR_TOP     = '1;
    localparam logic [SIZE:0]   COUNT_MAX   = {1'b1, {SIZE{1'b0}}};

    imem_state_t     r_state;
    imem_state_t     w_state_nxt;
    logic [SIZE-1:0] r_wr_ptr;
    logic [SIZE-1:0] w_wr_ptr_nxt;
    logic [SIZE:0]   r_byte_count;
    logic [SIZE:0]   w_count_nxt;
    logic            r_fetch_fault;
    logic            w_fault_nxt;
    logic            r_ld_ready;
    logic            r_cpu_stall;
    logic            r_load_done;
    logic            r_load_err;
    logic            w_fetch_bad;

    assign w_fetch_bad = fetch_addr_bad(64'(cpu_addr), SIZE);

    // State, pointer and status registers; status flags are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RESET_STATE;
            r_wr_ptr      <= '0;
            r_byte_count  <= '0;
            r_fetch_fault <= 1'b0;
            r_ld_ready    <= 1'b0;
            r_cpu_stall   <= ~BOOT_AUTO;
            r_load_done   <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_byte_count  <= w_count_nxt;
            r_fetch_fault <= w_fault_nxt;
            r_ld_ready    <= (w_state_nxt == LOAD);
            r_cpu_stall   <= (w_state_nxt != RUN);
            r_load_done   <= (w_state_nxt == DONE);
            r_load_err    <= (w_state_nxt == ERR);
        end
    end

    // Next-state logic and the combinational memory write strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_byte_count;
        w_fault_nxt  = r_fetch_fault;
        mem_we       = 1'b0;

        case (r_state)
            WAIT: begin
                w_state_nxt = WAIT;
            end
            LOAD: begin
                mem_we = ld_valid;
                if (ld_valid) begin
                    w_wr_ptr_nxt = r_wr_ptr + SIZE'(1);
                    if (r_byte_count != COUNT_MAX) begin
                        w_count_nxt = r_byte_count + (SIZE + 1)'(1);
                    end
                    if (ld_last) begin
                        w_state_nxt = DONE;
                    end else if (r_wr_ptr == PTR_TOP) begin
                        w_state_nxt = ERR;
                    end
                end
            end
            DONE: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_fetch_bad) begin
                    w_fault_nxt = 1'b1;
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase

        // A (re)load request overrides everything, including a byte accepted this cycle.
        if (load_start) begin
            w_state_nxt  = LOAD;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_fault_nxt  = 1'b0;
        end
    end

    assign mem_waddr   = r_wr_ptr;
    assign mem_wdata   = ld_byte;
    assign mem_raddr   = cpu_addr[SIZE-1:0];
    assign ld_ready    = r_ld_ready;
    assign cpu_stall   = r_cpu_stall;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;
    assign byte_count  = r_byte_count;
    assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed load/fetch sequences checked against a behavioural model.
module tb_imem_load_ctrl;

    localparam int unsigned SIZE  = 14;
    localparam int unsigned BYTES = 1 << SIZE;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              ld_valid;
    logic              ld_last;
    logic [7:0]        ld_byte;
    logic [31:0]       cpu_addr;
    logic              ld_ready;
    logic              mem_we;
    logic [SIZE-1:0]   mem_waddr;
    logic [7:0]        mem_wdata;
    logic [SIZE-1:0]   mem_raddr;
    logic              cpu_stall;
    logic              load_done;
    logic              load_err;
    logic [SIZE:0]     byte_count;
    logic              fetch_fault;

    logic [31:0]       a_cpu_addr;
    logic              a_ld_ready;
    logic              a_mem_we;
    logic [SIZE-1:0]   a_mem_waddr;
    logic [7:0]        a_mem_wdata;
    logic [SIZE-1:0]   a_mem_raddr;
    logic              a_cpu_stall;
    logic              a_load_done;
    logic              a_load_err;
    logic [SIZE:0]     a_byte_count;
    logic              a_fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem_arr [BYTES];
    logic [7:0] img [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    always #5 clk = ~clk;

    imem_load_ctrl #(.ADDRESS_WIDTH(32), .SIZE(SIZE), .BOOT_AUTO(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_byte(ld_byte), .ld_last(ld_last), .cpu_addr(cpu_addr),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
        .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err),
        .byte_count(byte_count), .fetch_fault(fetch_fault)
    );

    imem_load_ctrl #(.ADDRESS_WIDTH(32), .SIZE(SIZE), .BOOT_AUTO(1'b1)) u_dut_auto (
        .clk(clk), .rst(rst), .load_start(1'b0), .ld_valid(1'b0),
        .ld_ready(a_ld_ready), .ld_byte(8'h00), .ld_last(1'b0), .cpu_addr(a_cpu_addr),
        .mem_we(a_mem_we), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata), .mem_raddr(a_mem_raddr),
        .cpu_stall(a_cpu_stall), .load_done(a_load_done), .load_err(a_load_err),
        .byte_count(a_byte_count), .fetch_fault(a_fetch_fault)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit fetch_bad(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= BYTES - 4);
    endfunction

    // Behavioural model: load phase, byte count, completion pulse, error, running, fault.
    bit m_valid   = 1'b0;
    bit e_loading, e_done, e_err, e_run, e_fault;
    int e_count;

    always @(posedge clk) begin
        bit n_loading, n_done, n_err, n_run, n_fault;
        int n_count;
        if (rst) begin
            e_loading = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_run = 1'b0; e_fault = 1'b0; e_count = 0;
            m_valid = 1'b1;
        end else begin
            n_loading = e_loading; n_done = 1'b0; n_err = e_err;
            n_run = e_run; n_fault = e_fault; n_count = e_count;
            if (e_loading && ld_valid) begin
                n_count = (e_count + 1 > BYTES) ? BYTES : e_count + 1;
                if (ld_last) begin
                    n_loading = 1'b0; n_done = 1'b1;
                end else if (e_count == BYTES - 1) begin
                    n_loading = 1'b0; n_err = 1'b1;
                end
            end
            if (e_done) n_run = 1'b1;
            if (e_run && fetch_bad(cpu_addr)) n_fault = 1'b1;
            if (load_start) begin
                n_loading = 1'b1; n_count = 0; n_err = 1'b0;
                n_fault = 1'b0; n_run = 1'b0; n_done = 1'b0;
            end
            e_loading = n_loading; e_done = n_done; e_err = n_err;
            e_run = n_run; e_fault = n_fault; e_count = n_count;
        end
    end

    // Every-cycle comparison against the model, plus a mirror of written bytes.
    always @(negedge clk) begin
        if (mem_we === 1'b1) mem_arr[mem_waddr] = mem_wdata;
        if (m_valid) begin
            check("cpu_stall", 32'(cpu_stall), 32'(!e_run));
            check("ld_ready", 32'(ld_ready), 32'(e_loading));
            check("load_done", 32'(load_done), 32'(e_done));
            check("load_err", 32'(load_err), 32'(e_err));
            check("byte_count", 32'(byte_count), 32'(e_count));
            check("fetch_fault", 32'(fetch_fault), 32'(e_fault));
            check("mem_we", 32'(mem_we), 32'(e_loading && ld_valid));
            check("mem_raddr", 32'(mem_raddr), cpu_addr % BYTES);
            if (e_loading && ld_valid) begin
                check("mem_waddr", 32'(mem_waddr), 32'(e_count % BYTES));
                check("mem_wdata", 32'(mem_wdata), 32'(ld_byte));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_byte = 8'h00; cpu_addr = 32'h0; a_cpu_addr = 32'h0;
        tick();
        check("lit_reset_stall", 32'(cpu_stall), 32'd1);
        check("lit_auto_reset_stall", 32'(a_cpu_stall), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("lit_wait_stall", 32'(cpu_stall), 32'd1);
        check("lit_wait_ready", 32'(ld_ready), 32'd0);
        check("lit_wait_count", 32'(byte_count), 32'd0);
        a_cpu_addr = 32'h1;
        tick();
        check("lit_auto_fault", 32'(a_fetch_fault), 32'd1);
        check("lit_auto_run", 32'(a_cpu_stall), 32'd0);

        // 8-byte image
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("lit_load_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 8; i++) send_byte(img[i], i == 7);
        check("lit_done_pulse", 32'(load_done), 32'd1);
        check("lit_done_count", 32'(byte_count), 32'd8);
        check("lit_done_stall", 32'(cpu_stall), 32'd1);
        tick();
        check("lit_run_pulse_gone", 32'(load_done), 32'd0);
        check("lit_run_stall", 32'(cpu_stall), 32'd0);
        for (int i = 0; i < 8; i++) check("lit_img_byte", 32'(mem_arr[i]), 32'(img[i]));

        // fetch checks
        cpu_addr = 32'h0000_3FF8; tick();
        check("lit_fault_3ff8", 32'(fetch_fault), 32'd0);
        cpu_addr = 32'h0000_0002; tick();
        check("lit_fault_misalign", 32'(fetch_fault), 32'd1);
        cpu_addr = 32'h0; tick();
        check("lit_fault_sticky", 32'(fetch_fault), 32'd1);

        // gapped load
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("lit_fault_cleared", 32'(fetch_fault), 32'd0);
        send_byte(8'hAA, 1'b0); tick();
        send_byte(8'hBB, 1'b0); tick(); tick();
        send_byte(8'hCC, 1'b1);
        check("lit_gap_count", 32'(byte_count), 32'd3);
        tick();
        check("lit_gap_b0", 32'(mem_arr[0]), 32'hAA);
        check("lit_gap_b1", 32'(mem_arr[1]), 32'hBB);
        check("lit_gap_b2", 32'(mem_arr[2]), 32'hCC);
        check("lit_gap_b3", 32'(mem_arr[3]), 32'h00);
        cpu_addr = 32'h0000_3FFC; tick();
        check("lit_fault_3ffc", 32'(fetch_fault), 32'd1);
        cpu_addr = 32'h0;

        // restart mid-image, with a byte accepted in the restart cycle
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 1'b0);
        load_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h16;
        tick();
        load_start = 1'b0; ld_valid = 1'b0;
        check("lit_restart_count", 32'(byte_count), 32'd0);
        check("lit_restart_ready", 32'(ld_ready), 32'd1);
        check("lit_restart_b5", 32'(mem_arr[5]), 32'h16);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b1);
        check("lit_restart_b0", 32'(mem_arr[0]), 32'h21);
        check("lit_restart_b1", 32'(mem_arr[1]), 32'h22);
        check("lit_restart_len", 32'(byte_count), 32'd2);
        tick();
        cpu_addr = 32'h0001_0000; tick();
        check("lit_fault_upper", 32'(fetch_fault), 32'd1);
        cpu_addr = 32'h0;

        // overflow: one byte more than memory holds, no ld_last
        load_start = 1'b1; tick(); load_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < BYTES + 1; i++) begin
            ld_byte = (i == BYTES) ? 8'hEE : (8'(i) ^ 8'h5A);
            tick();
        end
        ld_valid = 1'b0;
        check("lit_ovf_err", 32'(load_err), 32'd1);
        check("lit_ovf_ready", 32'(ld_ready), 32'd0);
        check("lit_ovf_count", 32'(byte_count), 32'(BYTES));
        check("lit_ovf_top", 32'(mem_arr[BYTES-1]), 32'hA5);
        check("lit_ovf_nowrap", 32'(mem_arr[0]), 32'h5A);
        tick();
        check("lit_ovf_sticky", 32'(load_err), 32'd1);
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("lit_ovf_cleared", 32'(load_err), 32'd0);
        send_byte(8'h77, 1'b1);
        tick();
        check("lit_final_run", 32'(cpu_stall), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
